// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe stage register and its skid buffer.
package pipe_pkg;

    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle for the upstream and downstream sides of a pipe stage.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 128
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_nop;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_nop
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_nop
    );
endinterface

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer: output register plus one spill register, with in_ready
// driven from a flop so downstream ready never reaches upstream combinationally.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = 128,
    parameter logic [DATA_W-1:0] NOP_PAYLOAD = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_nop
);

    skid_state_e       state_r;
    skid_state_e       state_nx_s;
    logic [DATA_W-1:0] out_data_r;
    logic [DATA_W-1:0] out_data_nx_s;
    logic [DATA_W-1:0] skid_data_r;
    logic [DATA_W-1:0] skid_data_nx_s;
    logic              out_valid_r;
    logic              out_nop_r;
    logic              in_ready_r;
    logic              accept_s;
    logic              emit_s;

    assign accept_s = in_valid & in_ready_r;
    assign emit_s   = out_valid_r & out_ready;

    // Next-state and next-payload selection for the skid FSM.
    always_comb begin
        state_nx_s     = state_r;
        out_data_nx_s  = out_data_r;
        skid_data_nx_s = skid_data_r;
        if (flush) begin
            state_nx_s     = EMPTY;
            out_data_nx_s  = NOP_PAYLOAD;
            skid_data_nx_s = NOP_PAYLOAD;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        state_nx_s    = ONE;
                        out_data_nx_s = in_data;
                    end else begin
                        state_nx_s = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && emit_s) begin
                        out_data_nx_s = in_data;
                    end else if (accept_s) begin
                        state_nx_s     = FULL;
                        skid_data_nx_s = in_data;
                    end else if (emit_s) begin
                        state_nx_s    = EMPTY;
                        out_data_nx_s = NOP_PAYLOAD;
                    end else begin
                        state_nx_s = ONE;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the spilled word can move forward
                    if (emit_s) begin
                        state_nx_s     = ONE;
                        out_data_nx_s  = skid_data_r;
                        skid_data_nx_s = NOP_PAYLOAD;
                    end else begin
                        state_nx_s = FULL;
                    end
                end
                default: begin
                    state_nx_s     = EMPTY;
                    out_data_nx_s  = NOP_PAYLOAD;
                    skid_data_nx_s = NOP_PAYLOAD;
                end
            endcase
        end
    end

    // State, payload and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= EMPTY;
            out_data_r  <= NOP_PAYLOAD;
            skid_data_r <= NOP_PAYLOAD;
            out_valid_r <= 1'b0;
            out_nop_r   <= 1'b1;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_nx_s;
            out_data_r  <= out_data_nx_s;
            skid_data_r <= skid_data_nx_s;
            out_valid_r <= (state_nx_s != EMPTY);
            out_nop_r   <= (state_nx_s == EMPTY);
            in_ready_r  <= (state_nx_s != FULL);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_nop   = out_nop_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Registered pipeline stage with flush and stall/bubble counters.
// Define PIPE_STAGE_SKID_EN to use a 2-entry skid buffer with a registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = 128,
    parameter logic [DATA_W-1:0] NOP_PAYLOAD = {DATA_W{1'b0}},
    parameter int                CNT_W       = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    pipe_stage_reg_if.slave  bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic              in_ready_s;
    logic              out_valid_s;
    logic [DATA_W-1:0] out_data_s;
    logic              out_nop_s;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  bubble_cnt_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

`ifdef PIPE_STAGE_SKID_EN
    pipe_skid_buf #(
        .DATA_W      (DATA_W),
        .NOP_PAYLOAD (NOP_PAYLOAD)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .in_ready  (in_ready_s),
        .in_data   (bus.in_data),
        .out_valid (out_valid_s),
        .out_ready (bus.out_ready),
        .out_data  (out_data_s),
        .out_nop   (out_nop_s)
    );
`else
    logic              out_valid_r;
    logic              out_nop_r;
    logic [DATA_W-1:0] out_data_r;

    assign in_ready_s = bus.out_ready | ~out_valid_r;

    // Single output register: load on accept, empty on emit, kill on flush.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            out_valid_r <= 1'b0;
            out_nop_r   <= 1'b1;
            out_data_r  <= NOP_PAYLOAD;
        end else if (bus.in_valid && in_ready_s) begin
            out_valid_r <= 1'b1;
            out_nop_r   <= 1'b0;
            out_data_r  <= bus.in_data;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
            out_nop_r   <= 1'b1;
            out_data_r  <= NOP_PAYLOAD;
        end else begin
            out_valid_r <= out_valid_r;
            out_nop_r   <= out_nop_r;
            out_data_r  <= out_data_r;
        end
    end

    assign out_valid_s = out_valid_r;
    assign out_nop_s   = out_nop_r;
    assign out_data_s  = out_data_r;
`endif

    // Saturating stall/bubble counters; flush does not touch them.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r  <= {CNT_W{1'b0}};
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (out_valid_s && !bus.out_ready) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end
            if (!out_valid_s && bus.out_ready) begin
                bubble_cnt_r <= sat_inc(bubble_cnt_r);
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = out_data_s;
    assign bus.out_nop   = out_nop_s;
    assign stall_cnt     = stall_cnt_r;
    assign bubble_cnt    = bubble_cnt_r;

endmodule
